// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: iterative shift-add multiply / restoring divide for the Execute stage
//   Ports: CLK, RESET (sync, active-high), Start, MCycleOp (0 mul, 1 div),
//   Signed (only with MCYCLE_SIGNED_EN), Operand1/Operand2 in, Result1/Result2 out
//   (low/high product or quotient/remainder), Busy (stall), Done (one-cycle pulse).
//   Optional signed support is enabled by defining MCYCLE_SIGNED_EN.
module mcycle_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             Start,
  input  logic             MCycleOp,
`ifdef MCYCLE_SIGNED_EN
  input  logic             Signed,
`endif
  input  logic [WIDTH-1:0] Operand1,
  input  logic [WIDTH-1:0] Operand2,
  output logic [WIDTH-1:0] Result1,
  output logic [WIDTH-1:0] Result2,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = $clog2(WIDTH);
`ifdef MCYCLE_SIGNED_EN
  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic op_q, op_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d, r1_q, r1_d, r2_q, r2_d;
  logic [WIDTH-1:0] in_a_mag, in_b_mag, mag_a, mag_b;
`ifdef MCYCLE_SIGNED_EN
  logic sa_q, sa_d, sb_q, sb_d, in_sa, in_sb, fix_need;
  logic [2*WIDTH-1:0] prod_neg;
  assign in_sa = Signed & Operand1[WIDTH-1];
  assign in_sb = Signed & Operand2[WIDTH-1];
  assign in_a_mag = in_sa ? -Operand1 : Operand1;
  assign in_b_mag = in_sb ? -Operand2 : Operand2;
  assign mag_a = sa_q ? -a_q : a_q;
  assign mag_b = sb_q ? -b_q : b_q;
  // Division corrects quotient and/or remainder whenever either operand is negative
  assign fix_need = ~dz_q & (op_q ? (sa_q | sb_q) : (sa_q ^ sb_q));
  assign prod_neg = -{r2_q, r1_q};
`else
  assign in_a_mag = Operand1;
  assign in_b_mag = Operand2;
  assign mag_a = a_q;
  assign mag_b = b_q;
`endif
  // Multiply step: add multiplicand into the high half when the multiplier LSB is set, then shift right
  logic [WIDTH:0] sum, sh;
  logic [WIDTH-1:0] diff, hi_n, lo_n;
  logic ge;
  assign sum = {1'b0, hi_q} + {1'b0, lo_q[0] ? mag_a : '0};
  // Divide step: shift next dividend bit into the remainder, subtract divisor if it fits
  assign sh = {hi_q, lo_q[WIDTH-1]};
  assign ge = sh >= {1'b0, mag_b};
  assign diff = sh[WIDTH-1:0] - mag_b;
  assign hi_n = op_q ? (ge ? diff : sh[WIDTH-1:0]) : sum[WIDTH:1];
  assign lo_n = op_q ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    op_d = op_q;
    dz_d = dz_q;
    a_d = a_q;
    b_d = b_q;
    hi_d = hi_q;
    lo_d = lo_q;
    r1_d = r1_q;
    r2_d = r2_q;
`ifdef MCYCLE_SIGNED_EN
    sa_d = sa_q;
    sb_d = sb_q;
`endif
    case (state_q)
      IDLE: if (Start) begin
        state_d = RUN;
        cnt_d = '0;
        op_d = MCycleOp;
        dz_d = MCycleOp & (Operand2 == '0);
        a_d = Operand1;
        b_d = Operand2;
        hi_d = '0;
        lo_d = MCycleOp ? in_a_mag : in_b_mag;
`ifdef MCYCLE_SIGNED_EN
        sa_d = in_sa;
        sb_d = in_sb;
`endif
      end
      RUN: begin
        cnt_d = cnt_q + 1'b1;
        hi_d = hi_n;
        lo_d = lo_n;
        if (cnt_q == CW'(WIDTH - 1)) begin
          r1_d = dz_q ? '1 : lo_n;
          r2_d = dz_q ? a_q : hi_n;
`ifdef MCYCLE_SIGNED_EN
          state_d = fix_need ? FIX : DONE;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef MCYCLE_SIGNED_EN
      FIX: begin
        r1_d = op_q ? ((sa_q ^ sb_q) ? -r1_q : r1_q) : prod_neg[WIDTH-1:0];
        r2_d = op_q ? (sa_q ? -r2_q : r2_q) : prod_neg[2*WIDTH-1:WIDTH];
        state_d = DONE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q <= '0;
      op_q <= 1'b0;
      dz_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      hi_q <= '0;
      lo_q <= '0;
      r1_q <= '0;
      r2_q <= '0;
`ifdef MCYCLE_SIGNED_EN
      sa_q <= 1'b0;
      sb_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      dz_q <= dz_d;
      a_q <= a_d;
      b_q <= b_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
`ifdef MCYCLE_SIGNED_EN
      sa_q <= sa_d;
      sb_q <= sb_d;
`endif
    end
  end
`ifdef MCYCLE_SIGNED_EN
  assign Busy = (state_q == IDLE && Start) || state_q == RUN || state_q == FIX;
`else
  assign Busy = (state_q == IDLE && Start) || state_q == RUN;
`endif
  assign Done = state_q == DONE;
  assign Result1 = r1_q;
  assign Result2 = r2_q;
endmodule

// File: tb/tb_mcycle_sequencer.sv
// tb_mcycle_sequencer: self-checking bench for mcycle_sequencer
module tb_mcycle_sequencer;
  localparam int W = 32;
  logic CLK = 1'b0, RESET = 1'b1, Start = 1'b0, MCycleOp = 1'b0;
`ifdef MCYCLE_SIGNED_EN
  logic Signed = 1'b0;
`endif
  logic [W-1:0] Operand1 = '0, Operand2 = '0, Result1, Result2;
  logic Busy, Done;
  int checks = 0, failures = 0, cyc = 0;
  mcycle_sequencer #(.WIDTH(W)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .MCycleOp(MCycleOp),
`ifdef MCYCLE_SIGNED_EN
    .Signed(Signed),
`endif
    .Operand1(Operand1), .Operand2(Operand2), .Result1(Result1), .Result2(Result2),
    .Busy(Busy), .Done(Done));
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic void model(input logic op, input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] r1, output logic [W-1:0] r2, output int lat);
    longint sa, sb;
    logic [63:0] p;
    lat = W + 1;
    if (op && b == 0) begin
      r1 = '1;
      r2 = a;
      return;
    end
    if (!sg) begin
      if (op) begin
        r1 = a / b;
        r2 = a % b;
      end else begin
        p = 64'(a) * 64'(b);
        {r2, r1} = p;
      end
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op) begin
        r1 = W'(sa / sb);
        r2 = W'(sa % sb);
        lat = (a[W-1] | b[W-1]) ? W + 2 : W + 1;
      end else begin
        p = 64'(sa * sb);
        {r2, r1} = p;
        lat = (a[W-1] ^ b[W-1]) ? W + 2 : W + 1;
      end
    end
  endfunction
  task automatic issue(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input bit hold,
                       output int lat, output int done_at, output logic [W-1:0] r1, output logic [W-1:0] r2,
                       output int busy_bad, output logic busy_done);
    Start = 1'b1;
    MCycleOp = op;
    Operand1 = a;
    Operand2 = b;
    lat = -1;
    done_at = -1;
    r1 = '0;
    r2 = '0;
    busy_bad = 0;
    busy_done = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge CLK);
      if (Done) begin
        lat = c;
        done_at = cyc;
        r1 = Result1;
        r2 = Result2;
        busy_done = Busy;
        break;
      end
      if (Busy !== 1'b1) busy_bad++;
      @(posedge CLK);
      #1;
      MCycleOp = 1'($urandom);
      Operand1 = $urandom;
      Operand2 = $urandom;
    end
    @(posedge CLK);
    #1;
    if (!hold) Start = 1'b0;
  endtask
  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
    @(negedge CLK);
    checks += 4;
    if (Busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", Done); end
    if (Result1 !== '0) begin failures++; $display("FAIL reset_r1: got %h expected 0", Result1); end
    if (Result2 !== '0) begin failures++; $display("FAIL reset_r2: got %h expected 0", Result2); end
    @(posedge CLK);
    #1;
  endtask
  task automatic test_mul_max();
    int lat, da, bb;
    logic bd;
    logic [W-1:0] r1, r2;
    issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, da, r1, r2, bb, bd);
    checks += 5;
    if (lat !== 33) begin failures++; $display("FAIL mulmax_lat: got %0d expected 33", lat); end
    if (bb !== 0) begin failures++; $display("FAIL mulmax_busy: got %0d low cycles expected 0", bb); end
    if (bd !== 1'b0) begin failures++; $display("FAIL mulmax_busy_done: got %b expected 0", bd); end
    if (r2 !== 32'hFFFF_FFFE) begin failures++; $display("FAIL mulmax_r2: got %h expected fffffffe", r2); end
    if (r1 !== 32'h0000_0001) begin failures++; $display("FAIL mulmax_r1: got %h expected 00000001", r1); end
  endtask
  task automatic test_div();
    int lat, da, bb;
    logic bd;
    logic [W-1:0] r1, r2;
    issue(1'b1, 32'd100, 32'd7, 1'b0, lat, da, r1, r2, bb, bd);
    checks += 4;
    if (lat !== 33) begin failures++; $display("FAIL div_lat: got %0d expected 33", lat); end
    if (r1 !== 32'd14) begin failures++; $display("FAIL div_q: got %0d expected 14", r1); end
    if (r2 !== 32'd2) begin failures++; $display("FAIL div_r: got %0d expected 2", r2); end
    if (bb !== 0) begin failures++; $display("FAIL div_busy: got %0d low cycles expected 0", bb); end
    @(negedge CLK);
    checks += 2;
    if (Busy !== 1'b0) begin failures++; $display("FAIL div_no_restart_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0) begin failures++; $display("FAIL div_done_pulse: got %b expected 0", Done); end
    @(posedge CLK);
    #1;
  endtask
  task automatic test_divzero();
    int lat, da, bb;
    logic bd;
    logic [W-1:0] r1, r2;
    issue(1'b1, 32'd5, 32'd0, 1'b0, lat, da, r1, r2, bb, bd);
    checks += 3;
    if (lat !== 33) begin failures++; $display("FAIL dz_lat: got %0d expected 33", lat); end
    if (r1 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL dz_q: got %h expected ffffffff", r1); end
    if (r2 !== 32'd5) begin failures++; $display("FAIL dz_r: got %h expected 5", r2); end
  endtask
  task automatic test_reset_midrun();
    int lat, da, bb;
    logic bd;
    logic [W-1:0] r1, r2;
    Start = 1'b1;
    MCycleOp = 1'b0;
    Operand1 = 32'd3;
    Operand2 = 32'd4;
    repeat (10) begin
      @(posedge CLK);
      #1;
    end
    RESET = 1'b1;
    @(posedge CLK);
    #1 RESET = 1'b0;
    Start = 1'b0;
    @(negedge CLK);
    checks += 4;
    if (Busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", Busy); end
    if (Done !== 1'b0) begin failures++; $display("FAIL midrst_done: got %b expected 0", Done); end
    if (Result1 !== '0) begin failures++; $display("FAIL midrst_r1: got %h expected 0", Result1); end
    if (Result2 !== '0) begin failures++; $display("FAIL midrst_r2: got %h expected 0", Result2); end
    @(posedge CLK);
    #1;
    issue(1'b0, 32'd3, 32'd4, 1'b0, lat, da, r1, r2, bb, bd);
    checks += 3;
    if (lat !== 33) begin failures++; $display("FAIL midrst_rerun_lat: got %0d expected 33", lat); end
    if (r1 !== 32'd12) begin failures++; $display("FAIL midrst_rerun_r1: got %0d expected 12", r1); end
    if (r2 !== 32'd0) begin failures++; $display("FAIL midrst_rerun_r2: got %0d expected 0", r2); end
  endtask
  task automatic test_back_to_back();
    int lat1, lat2, d1, d2, bb, t0;
    logic bd;
    logic [W-1:0] a1, b1, a2, b2;
    issue(1'b0, 32'd2, 32'd3, 1'b1, lat1, d1, a1, b1, bb, bd);
    t0 = d1 - lat1;
    issue(1'b0, 32'd5, 32'd6, 1'b0, lat2, d2, a2, b2, bb, bd);
    checks += 4;
    if (d1 - t0 !== 33) begin failures++; $display("FAIL b2b_done1: got cycle %0d expected 33", d1 - t0); end
    if (d2 - t0 !== 67) begin failures++; $display("FAIL b2b_done2: got cycle %0d expected 67", d2 - t0); end
    if (a1 !== 32'd6) begin failures++; $display("FAIL b2b_r1_first: got %0d expected 6", a1); end
    if (a2 !== 32'd30) begin failures++; $display("FAIL b2b_r1_second: got %0d expected 30", a2); end
  endtask
`ifdef MCYCLE_SIGNED_EN
  task automatic test_signed();
    int lat, da, bb;
    logic bd;
    logic [W-1:0] r1, r2;
    Signed = 1'b1;
    issue(1'b1, -32'sd7, 32'd2, 1'b0, lat, da, r1, r2, bb, bd);
    checks += 4;
    if (lat !== 34) begin failures++; $display("FAIL sdiv_lat: got %0d expected 34", lat); end
    if (r1 !== 32'hFFFF_FFFD) begin failures++; $display("FAIL sdiv_q: got %h expected fffffffd", r1); end
    if (r2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL sdiv_r: got %h expected ffffffff", r2); end
    if (bb !== 0) begin failures++; $display("FAIL sdiv_busy: got %0d low cycles expected 0", bb); end
    issue(1'b0, -32'sd2, 32'd3, 1'b0, lat, da, r1, r2, bb, bd);
    checks += 2;
    if (r2 !== 32'hFFFF_FFFF) begin failures++; $display("FAIL smul_hi: got %h expected ffffffff", r2); end
    if (r1 !== 32'hFFFF_FFFA) begin failures++; $display("FAIL smul_lo: got %h expected fffffffa", r1); end
    Signed = 1'b0;
  endtask
`endif
  task automatic test_random();
    int lat, da, bb, elat;
    logic bd, op, sg;
    logic [W-1:0] a, b, r1, r2, e1, e2;
    for (int i = 0; i < 40; i++) begin
      op = 1'($urandom);
      sg = 1'b0;
`ifdef MCYCLE_SIGNED_EN
      sg = 1'($urandom);
      Signed = sg;
`endif
      a = ($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(0, 1000));
      b = ($urandom_range(0, 7) == 0) ? '0 : (($urandom_range(0, 1) == 0) ? $urandom : W'($urandom_range(1, 300)));
      model(op, sg, a, b, e1, e2, elat);
      issue(op, a, b, 1'($urandom), lat, da, r1, r2, bb, bd);
      checks += 4;
      if (lat !== elat) begin failures++; $display("FAIL rnd%0d_lat: got %0d expected %0d", i, lat, elat); end
      if (r1 !== e1) begin failures++; $display("FAIL rnd%0d_r1 op=%b a=%h b=%h: got %h expected %h", i, op, a, b, r1, e1); end
      if (r2 !== e2) begin failures++; $display("FAIL rnd%0d_r2 op=%b a=%h b=%h: got %h expected %h", i, op, a, b, r2, e2); end
      if (bb !== 0) begin failures++; $display("FAIL rnd%0d_busy: got %0d low cycles expected 0", i, bb); end
    end
    Start = 1'b0;
  endtask
  initial begin
    test_reset();
    test_mul_max();
    test_div();
    test_divzero();
    test_reset_midrun();
    test_back_to_back();
`ifdef MCYCLE_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
